// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
//   Command channel between a register/command master and counter_ctrl.
//   Ports (signals):
//     cmd_valid  master -> slave  command present
//     cmd_ready  slave  -> master command accepted when valid & ready
//     cmd_op     master -> slave  0 LOAD, 1 START, 2 STOP, 3 CLEAR
//     cmd_data   master -> slave  limit value for LOAD
`timescale 1ns/1ps

interface counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Command-driven sequencer for a WIDTH-bit up-counter with a programmable
//   terminal limit. One-shot or periodic operation, pause/resume/clear and
//   terminal-event reporting.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     cmd            command channel (counter_ctrl_if.slave)
//     mode_periodic  sampled at each match: 1 periodic, 0 one-shot
//     count          current count (registered)
//     busy           high while in RUN
//     done_pulse     one-cycle pulse per terminal match
//     wrap_cnt       periodic match count, saturating at 255
//   Optional build macro: COUNTER_CTRL_PRESCALE_EN enables a divide-by-PRE_DIV
//   prescaler that gates count steps and match evaluation in RUN.
//
//   state | meaning
//   IDLE  | cleared, waiting for START
//   RUN   | counting toward limit
//   PAUSE | stopped, count held, START resumes
//   DONE  | one-shot match reached, count held at limit
`timescale 1ns/1ps

module counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRE_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_ctrl_if.slave      cmd,
  input  logic               mode_periodic,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done_pulse,
  output logic [7:0]         wrap_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             done_q, done_d;

  logic cmd_acc;
  logic op_start, op_stop, op_clear;
  logic tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int PSW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRE_DIV - 1);

  logic [PSW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PS_LAST);
`else
  logic unused_pre_div;

  assign unused_pre_div = (PRE_DIV == 0);
  assign tick = 1'b1;
`endif

  // LOAD would change the limit under a running compare, so it stalls in RUN.
  assign cmd.cmd_ready = !((state_q == ST_RUN) && (cmd.cmd_op == OP_LOAD));
  assign cmd_acc       = cmd.cmd_valid && cmd.cmd_ready;
  assign op_start      = cmd_acc && (cmd.cmd_op == OP_START);
  assign op_stop       = cmd_acc && (cmd.cmd_op == OP_STOP);
  assign op_clear      = cmd_acc && (cmd.cmd_op == OP_CLEAR);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
    presc_d = presc_q;
`endif

    if (cmd_acc && (cmd.cmd_op == OP_LOAD)) begin
      limit_d = cmd.cmd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          state_d = ST_RUN;
          count_d = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
          presc_d = '0;
`endif
        end
      end

      ST_RUN: begin
        if (op_clear) begin
          // CLEAR wins over a coincident match: no pulse, no wrap increment.
          state_d = ST_IDLE;
          count_d = '0;
          wrap_d  = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
          presc_d = '0;
`endif
        end else if (tick && (count_q == limit_q)) begin
          done_d = 1'b1;
`ifdef COUNTER_CTRL_PRESCALE_EN
          presc_d = '0;
`endif
          if (mode_periodic) begin
            count_d = '0;
            if (wrap_q != 8'hFF) begin
              wrap_d = wrap_q + 8'd1;
            end
            // A STOP on the match edge still lets the wrap complete.
            if (op_stop) begin
              state_d = ST_PAUSE;
            end
          end else begin
            state_d = ST_DONE;
          end
        end else if (op_stop) begin
          state_d = ST_PAUSE;
        end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
          if (tick) begin
            count_d = count_q + 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
`else
          count_d = count_q + 1'b1;
`endif
        end
      end

      ST_PAUSE: begin
        if (op_clear) begin
          state_d = ST_IDLE;
          count_d = '0;
          wrap_d  = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
          presc_d = '0;
`endif
        end else if (op_start) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (op_clear) begin
          state_d = ST_IDLE;
          count_d = '0;
          wrap_d  = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
          presc_d = '0;
`endif
        end else if (op_start) begin
          state_d = ST_RUN;
          count_d = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
          presc_d = '0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '1;
      wrap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTER_CTRL_PRESCALE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  assign count      = count_q;
  assign busy       = (state_q == ST_RUN);
  assign done_pulse = done_q;
  assign wrap_cnt   = wrap_q;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit up-counter datapath.
- Owns the count register and a programmable terminal limit.
- Runs the count in one-shot or periodic mode, supports pause/resume/clear, and reports terminal events.
- Sits between a register/command master and downstream logic consuming count, done_pulse and wrap_cnt.

Parameters:
- WIDTH, 4: counter and limit width in bits.
- PRE_DIV, 4: prescale divide ratio, integer >= 1; used only when COUNTER_CTRL_PRESCALE_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted at this edge when valid and ready are both 1.
- cmd_op  input  2  opcode: 0 LOAD, 1 START, 2 STOP, 3 CLEAR.
- cmd_data  input  WIDTH  limit value for LOAD; ignored for other ops.
- mode_periodic  input  1  sampled at each match: 1 = periodic, 0 = one-shot.
- count  output  WIDTH  current count, registered.
- busy  output  1  high when state is RUN, registered.
- done_pulse  output  1  one-cycle pulse per terminal match, registered.
- wrap_cnt  output  8  number of periodic matches, saturates at 255.

Behaviour:
- Reset values: state IDLE, count 0, limit all-ones, busy 0, done_pulse 0, wrap_cnt 0.
- States: IDLE, RUN, PAUSE, DONE. A command takes effect on its accept edge.
- cmd_ready is combinational: 0 only when state is RUN and cmd_op is LOAD; 1 otherwise. A LOAD issued in RUN stalls until the state leaves RUN.
- LOAD: limit <= cmd_data. Count and state are unchanged.
- IDLE:
  - START -> RUN with count 0. No increment on the accept edge.
  - STOP and CLEAR: no effect.
- RUN:
  - On each edge with count != limit, count <= count + 1.
  - Match: count == limit at an edge.
  - Periodic match: count <= 0; done_pulse high next cycle; wrap_cnt +1 (saturating at 255); stay in RUN.
  - One-shot match: go to DONE; count holds at limit; done_pulse high next cycle.
  - STOP: go to PAUSE; count holds with no increment on that edge.
  - CLEAR: go to IDLE; count 0; wrap_cnt 0.
  - START: accepted and ignored.
- Period in periodic mode: limit+1 cycles.
- limit = 0 in periodic mode: done_pulse high every cycle; count stays 0.
- Simultaneous events in RUN:
  - CLEAR beats a match: no done_pulse, no wrap increment.
  - STOP together with a match: the match is processed in full. Periodic then goes to PAUSE with count 0; one-shot goes to DONE and the STOP is dropped.
- PAUSE: START -> RUN, resuming from the held count. CLEAR -> IDLE (count 0, wrap_cnt 0). STOP: ignored.
- DONE: START -> RUN with count 0. CLEAR -> IDLE. STOP: ignored. busy is 0.
- A limit below the current count, loaded while in PAUSE, causes count to increment to all-ones, wrap to 0, and match on the next pass. No special handling.
- rst asserted mid-operation returns every output to its reset value immediately, with no done_pulse.

Optional Feature:
- Macro COUNTER_CTRL_PRESCALE_EN.
- When defined:
  - A prescaler of width clog2(PRE_DIV) runs in RUN only.
  - Count increments and match evaluation happen only on the edge where the prescaler equals PRE_DIV-1; the prescaler then wraps to 0.
  - The prescaler holds in PAUSE and clears on reset, CLEAR, and START from IDLE or DONE.
  - Periodic period is (limit+1)*PRE_DIV cycles.
- When undefined: no prescaler logic; count steps every RUN cycle and PRE_DIV is ignored.

Test Plan:
- Reset, then LOAD 5, mode_periodic=1, START -> count 0,1,...,5,0,1; done_pulse one cycle after each 5->0 step, every 6 cycles; wrap_cnt 1 then 2.
- LOAD 3, mode_periodic=0, START -> count 0,1,2,3 then holds at 3; state DONE, busy 0; exactly one done_pulse. A second START restarts from 0.
- Periodic run with limit 7; STOP at count 4; hold 10 cycles; START -> count stays 4 during PAUSE, then resumes 5,6,7,0. A LOAD issued during RUN keeps cmd_ready low until PAUSE.
- Periodic run, limit 2; CLEAR asserted on the match edge -> no done_pulse; count 0; wrap_cnt 0; state IDLE.
- limit 0, periodic -> done_pulse high continuously; wrap_cnt saturates at 255 after 255 cycles; rst asserted mid-run -> all outputs 0 asynchronously.
- With COUNTER_CTRL_PRESCALE_EN and PRE_DIV=4, limit 2, periodic -> count steps every 4 cycles; done_pulse every 12 cycles.
